branch_enable_logic: RTL

Condition-code and branch-enable stage for the LC-3 datapath. It sits directly downstream of the NZP flag logic: it registers the N/Z/P flags into the architectural condition-code register and compares them against the IR[11:9] nzp field. On a request/acknowledge handshake from the control FSM it produces the registered BEN bit used by the BR decision. It also keeps a saturating count of taken branches for debug.

---
 rtl/branch_enable_logic.sv | 93 +++++++++
 1 files changed

// File: rtl/branch_enable_logic.sv
// rtl/branch_enable_logic.sv - LC-3 condition-code register and branch-enable (BEN) stage.
// Registers N/Z/P into CC, evaluates BEN against IR[11:9] on a req/ack handshake, counts taken branches.
module branch_enable_logic #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 N,
  input  logic                 Z,
  input  logic                 P,
  input  logic                 Load_CC,
  input  logic [2:0]           IR_NZP,
  input  logic                 Eval_Req,
  input  logic                 Clear_Count,
  output logic [2:0]           CC,
  output logic                 BEN,
  output logic                 Eval_Ack,
  output logic                 Eval_Busy,
  output logic [CNT_WIDTH-1:0] Taken_Count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [2:0]           cc_q, cc_d;
  logic [2:0]           nzp_q, nzp_d;
  logic                 ben_q, ben_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cc_q    <= 3'b010;
      nzp_q   <= 3'b000;
      ben_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      nzp_q   <= nzp_d;
      ben_q   <= ben_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    nzp_d   = nzp_q;
    ben_d   = ben_q;
    cnt_d   = cnt_q;
    // CC loads in every state; the evaluation below sees the pre-edge value.
    cc_d    = Load_CC ? {N, Z, P} : cc_q;

    case (state_q)
      S_IDLE: begin
        if (Eval_Req) begin
          nzp_d   = IR_NZP;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        ben_d = |(nzp_q & cc_q);
        if (ben_d && (cnt_q != {CNT_WIDTH{1'b1}})) begin
          cnt_d = cnt_q + CNT_ONE;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (Clear_Count) begin
      cnt_d = '0;
    end
  end

  assign CC          = cc_q;
  assign BEN         = ben_q;
  assign Eval_Ack    = (state_q == S_DONE);
  assign Eval_Busy   = (state_q != S_IDLE);
  assign Taken_Count = cnt_q;

endmodule
